// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS load/store bus adapter.
//   size_t  : request access size encoding (3 is not a legal size)
//   state_t : adapter FSM states
//   err_t   : response error codes reported to the core
package mips_bus_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        RDATA = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_TIMEOUT  = 2'd2
    } err_t;

endpackage

// File: rtl/mips_bus_lane_align.sv
// Combinational byte-lane logic for the load/store bus adapter.
// Ports:
//   req_addr_lo, req_size, req_wdata : incoming request (store side)
//   misalign                         : request violates natural alignment
//   lane_be, lane_wdata              : byteenable / lane-shifted store data
//   ld_addr_lo, ld_size, ld_signed   : registered attributes of the load in flight
//   rdata                            : raw bus read data
//   ld_data                          : lane extracted to bit 0 and extended
module mips_bus_lane_align
    import mips_bus_pkg::*;
(
    input  logic [1:0]  req_addr_lo,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        misalign,
    output logic [3:0]  lane_be,
    output logic [31:0] lane_wdata,
    input  logic [1:0]  ld_addr_lo,
    input  logic [1:0]  ld_size,
    input  logic        ld_signed,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        misalign   = 1'b0;
        lane_be    = 4'b0000;
        lane_wdata = 32'h0;
        case (req_size)
            SIZE_B: begin
                lane_be    = 4'b0001 << req_addr_lo;
                lane_wdata = {24'h0, req_wdata[7:0]} << {req_addr_lo, 3'b000};
            end
            SIZE_H: begin
                misalign   = req_addr_lo[0];
                lane_be    = req_addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_wdata = req_addr_lo[1] ? {req_wdata[15:0], 16'h0}
                                            : {16'h0, req_wdata[15:0]};
            end
            SIZE_W: begin
                misalign   = (req_addr_lo != 2'b00);
                lane_be    = 4'b1111;
                lane_wdata = req_wdata;
            end
            default: misalign = 1'b1;
        endcase
    end

    always_comb begin
        shifted = rdata >> {ld_addr_lo, 3'b000};
        case (ld_size)
            SIZE_B:  ld_data = {{24{ld_signed & shifted[7]}}, shifted[7:0]};
            SIZE_H:  ld_data = {{16{ld_signed & shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;   // word loads are always at offset 0
        endcase
    end

endmodule

// File: rtl/mips_bus_lsu.sv
// Load/store adapter between the MIPS core and an Avalon-style memory bus.
// One request at a time; the bus transaction is registered and held through
// waitrequest, load data is extracted/extended one cycle after the read is
// accepted, and the core gets a one-cycle resp_valid pulse.
// Ports:
//   clk, reset (async, active low)
//   req_*  : core request handshake (req_ready high only in IDLE)
//   resp_* : completion pulse, load data, error code
//   address/read/write/writedata/byteenable/waitrequest/readdata : bus side
// Parameter TIMEOUT_CYCLES: waitrequest-high cycles before abandoning (0 = never).
//
// state | meaning
// IDLE  | ready for a request
// BUS   | strobe asserted, waiting for waitrequest low
// RDATA | sample readdata and extend into resp_rdata
// RESP  | resp_valid pulse, back to IDLE
module mips_bus_lsu
    import mips_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT_CYCLES);

    state_t      state;
    logic [CW-1:0] wait_cnt;
    logic        op_write;
    logic        op_signed;
    logic [1:0]  op_size;
    logic [1:0]  op_lo;

    logic        misalign;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] ld_data;
    logic        timeout_hit;

    mips_bus_lane_align u_lane (
        .req_addr_lo (req_addr[1:0]),
        .req_size    (req_size),
        .req_wdata   (req_wdata),
        .misalign    (misalign),
        .lane_be     (lane_be),
        .lane_wdata  (lane_wdata),
        .ld_addr_lo  (op_lo),
        .ld_size     (op_size),
        .ld_signed   (op_signed),
        .rdata       (readdata),
        .ld_data     (ld_data)
    );

    assign req_ready = (state == IDLE);

    // Fires on the TIMEOUT_CYCLES-th stalled cycle so the strobe is high for
    // exactly that many waitrequest cycles.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && waitrequest &&
                         ((wait_cnt + 1'b1) == WAIT_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            op_write   <= 1'b0;
            op_signed  <= 1'b0;
            op_size    <= 2'd0;
            op_lo      <= 2'd0;
            address    <= 32'h0;
            read       <= 1'b0;
            write      <= 1'b0;
            writedata  <= 32'h0;
            byteenable <= 4'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= ERR_NONE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_write  <= req_write;
                        op_signed <= req_signed;
                        op_size   <= req_size;
                        op_lo     <= req_addr[1:0];
                        if (misalign) begin
                            resp_valid <= 1'b1;
                            resp_err   <= ERR_MISALIGN;
                            resp_rdata <= 32'h0;
                            state      <= RESP;
                        end else begin
                            address    <= {req_addr[31:2], 2'b00};
                            byteenable <= lane_be;
                            writedata  <= lane_wdata;
                            read       <= ~req_write;
                            write      <= req_write;
                            wait_cnt   <= '0;
                            state      <= BUS;
                        end
                    end
                end
                BUS: begin
                    if (!waitrequest) begin
                        read  <= 1'b0;
                        write <= 1'b0;
                        if (op_write) begin
                            resp_valid <= 1'b1;
                            resp_err   <= ERR_NONE;
                            resp_rdata <= 32'h0;
                            state      <= RESP;
                        end else begin
                            state <= RDATA;
                        end
                    end else if (timeout_hit) begin
                        read       <= 1'b0;
                        write      <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= ERR_TIMEOUT;
                        resp_rdata <= 32'h0;
                        state      <= RESP;
                    end else if (wait_cnt != WAIT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RDATA: begin
                    resp_rdata <= ld_data;
                    resp_err   <= ERR_NONE;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_bus_lsu.sv
module tb_mips_bus_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        rd;
        logic        wr;
        int          bcyc;
        int          lat;
        logic [31:0] rdata;
        logic [1:0]  err;
        bit          stable;
        bit          both;
        bit          ready;
    } txn_t;

    txn_t exp_q[$];

    mips_bus_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .waitrequest (waitrequest),
        .readdata    (readdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic txn_t mk(input logic [31:0] a, input logic [3:0] be,
                                input logic [31:0] wd, input logic rd, input logic wr,
                                input int bc, input int lat,
                                input logic [31:0] rdata, input logic [1:0] err);
        txn_t t;
        t.addr = a; t.be = be; t.wd = wd; t.rd = rd; t.wr = wr;
        t.bcyc = bc; t.lat = lat; t.rdata = rdata; t.err = err;
        t.stable = 1; t.both = 0; t.ready = 1;
        return t;
    endfunction

    // Drives one request and plays the bus slave: waitrequest high for the
    // first nwait strobe cycles, readdata valid only in the cycle after the
    // read is accepted. lat counts cycles after the accepting edge.
    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int nwait, input logic [31:0] rd_val, output txn_t o);
        int bc;
        bit data_next;
        o = mk(32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 0, -1, 32'h0, 2'd0);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        waitrequest = (nwait > 0);
        readdata = 32'hA5A5A5A5;
        o.ready = req_ready;
        @(negedge clk);
        req_valid = 1'b0; req_addr = 32'hFFFFFFFF; req_wdata = 32'h0;
        req_size = 2'd3; req_signed = ~sg;
        bc = 0;
        data_next = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            readdata = data_next ? rd_val : 32'hA5A5A5A5;
            data_next = 0;
            if (resp_valid) begin
                o.lat = cyc; o.rdata = resp_rdata; o.err = resp_err;
                break;
            end
            if (read && write) o.both = 1;
            if (read || write) begin
                bc++;
                if (bc == 1) begin
                    o.addr = address; o.be = byteenable; o.wd = writedata;
                    o.rd = read; o.wr = write;
                end else if (address !== o.addr || byteenable !== o.be ||
                             writedata !== o.wd || read !== o.rd || write !== o.wr) begin
                    o.stable = 0;
                end
                waitrequest = (bc <= nwait);
                data_next = read && !waitrequest;
            end
            @(negedge clk);
        end
        o.bcyc = bc;
    endtask

    task automatic test_reset();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset.req_ready got=%b exp=1", req_ready); end
        n_checks++; if (read !== 1'b0 || write !== 1'b0) begin n_fail++; $display("FAIL reset.strobes got=%b%b exp=00", read, write); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset.resp_valid got=%b exp=0", resp_valid); end
        n_checks++; if (address !== 32'h0 || writedata !== 32'h0 || byteenable !== 4'h0) begin
            n_fail++; $display("FAIL reset.bus got addr=%h wd=%h be=%b exp zeros", address, writedata, byteenable); end
        n_checks++; if (resp_rdata !== 32'h0 || resp_err !== 2'd0) begin
            n_fail++; $display("FAIL reset.resp got rdata=%h err=%0d exp 0/0", resp_rdata, resp_err); end
    endtask

    task automatic test_word_store();
        txn_t e, o;
        exp_q.push_back(mk(32'hBFC00108, 4'b1111, 32'h11223344, 1'b0, 1'b1, 1, 2, 32'h0, 2'd0));
        issue(1'b1, 2'd2, 1'b0, 32'hBFC00108, 32'h11223344, 0, 32'h0, o);
        e = exp_q.pop_front();
        n_checks++; if (o.ready !== e.ready) begin n_fail++; $display("FAIL word_store.ready got=%b exp=%b", o.ready, e.ready); end
        n_checks++; if (o.addr !== e.addr) begin n_fail++; $display("FAIL word_store.addr got=%h exp=%h", o.addr, e.addr); end
        n_checks++; if (o.wr !== e.wr || o.rd !== e.rd || o.both !== e.both) begin
            n_fail++; $display("FAIL word_store.strobe got rd=%b wr=%b both=%b exp rd=%b wr=%b", o.rd, o.wr, o.both, e.rd, e.wr); end
        n_checks++; if (o.be !== e.be) begin n_fail++; $display("FAIL word_store.be got=%b exp=%b", o.be, e.be); end
        n_checks++; if (o.wd !== e.wd) begin n_fail++; $display("FAIL word_store.wd got=%h exp=%h", o.wd, e.wd); end
        n_checks++; if (o.lat !== e.lat || o.bcyc !== e.bcyc) begin
            n_fail++; $display("FAIL word_store.timing got lat=%0d bus=%0d exp lat=%0d bus=%0d", o.lat, o.bcyc, e.lat, e.bcyc); end
        n_checks++; if (o.err !== e.err || o.rdata !== e.rdata) begin
            n_fail++; $display("FAIL word_store.resp got err=%0d rdata=%h exp err=%0d rdata=%h", o.err, o.rdata, e.err, e.rdata); end
    endtask

    task automatic test_byte_load();
        txn_t e, o;
        exp_q.push_back(mk(32'hBFC00100, 4'b1000, 32'h0, 1'b1, 1'b0, 1, 3, 32'hFFFFFFEE, 2'd0));
        exp_q.push_back(mk(32'hBFC00100, 4'b1000, 32'h0, 1'b1, 1'b0, 1, 3, 32'h000000EE, 2'd0));
        for (int s = 1; s >= 0; s--) begin
            issue(1'b0, 2'd0, s[0], 32'hBFC00103, 32'h0, 0, 32'hEE000000, o);
            e = exp_q.pop_front();
            n_checks++; if (o.addr !== e.addr || o.be !== e.be || o.rd !== e.rd || o.wr !== e.wr) begin
                n_fail++; $display("FAIL byte_load%0d.bus got addr=%h be=%b rd=%b wr=%b exp addr=%h be=%b rd=%b wr=%b",
                                   s, o.addr, o.be, o.rd, o.wr, e.addr, e.be, e.rd, e.wr); end
            n_checks++; if (o.lat !== e.lat) begin n_fail++; $display("FAIL byte_load%0d.lat got=%0d exp=%0d", s, o.lat, e.lat); end
            n_checks++; if (o.rdata !== e.rdata || o.err !== e.err) begin
                n_fail++; $display("FAIL byte_load%0d.rdata got=%h err=%0d exp=%h err=%0d", s, o.rdata, o.err, e.rdata, e.err); end
        end
    endtask

    task automatic test_half_access();
        txn_t e, o;
        exp_q.push_back(mk(32'hBFC00100, 4'b1100, 32'hABCD0000, 1'b0, 1'b1, 1, 2, 32'h0, 2'd0));
        issue(1'b1, 2'd1, 1'b0, 32'hBFC00102, 32'h0000ABCD, 0, 32'h0, o);
        e = exp_q.pop_front();
        n_checks++; if (o.be !== e.be || o.wd !== e.wd) begin
            n_fail++; $display("FAIL half_store.lanes got be=%b wd=%h exp be=%b wd=%h", o.be, o.wd, e.be, e.wd); end
        n_checks++; if (o.lat !== e.lat || o.err !== e.err) begin
            n_fail++; $display("FAIL half_store.resp got lat=%0d err=%0d exp lat=%0d err=%0d", o.lat, o.err, e.lat, e.err); end

        exp_q.push_back(mk(32'hBFC00100, 4'b0010, 32'h00005A00, 1'b0, 1'b1, 1, 2, 32'h0, 2'd0));
        issue(1'b1, 2'd0, 1'b0, 32'hBFC00101, 32'h1234565A, 0, 32'h0, o);
        e = exp_q.pop_front();
        n_checks++; if (o.be !== e.be || o.wd !== e.wd) begin
            n_fail++; $display("FAIL byte_store.lanes got be=%b wd=%h exp be=%b wd=%h", o.be, o.wd, e.be, e.wd); end

        exp_q.push_back(mk(32'hBFC00100, 4'b1100, 32'h0, 1'b1, 1'b0, 1, 3, 32'hFFFF8001, 2'd0));
        issue(1'b0, 2'd1, 1'b1, 32'hBFC00102, 32'h0, 0, 32'h80011234, o);
        e = exp_q.pop_front();
        n_checks++; if (o.be !== e.be || o.rdata !== e.rdata || o.lat !== e.lat) begin
            n_fail++; $display("FAIL half_load.signed got be=%b rdata=%h lat=%0d exp be=%b rdata=%h lat=%0d",
                               o.be, o.rdata, o.lat, e.be, e.rdata, e.lat); end
    endtask

    task automatic test_misaligned();
        txn_t e, o;
        // Misaligned requests go straight from IDLE to RESP: pulse one cycle after accept.
        exp_q.push_back(mk(32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 0, 1, 32'h0, 2'd1));
        exp_q.push_back(mk(32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 0, 1, 32'h0, 2'd1));
        exp_q.push_back(mk(32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 0, 1, 32'h0, 2'd1));
        issue(1'b0, 2'd1, 1'b1, 32'hBFC00101, 32'h0, 0, 32'hFFFFFFFF, o);
        e = exp_q.pop_front();
        n_checks++; if (o.bcyc !== e.bcyc) begin n_fail++; $display("FAIL misalign_half.bus_cycles got=%0d exp=%0d", o.bcyc, e.bcyc); end
        n_checks++; if (o.err !== e.err || o.rdata !== e.rdata) begin
            n_fail++; $display("FAIL misalign_half.resp got err=%0d rdata=%h exp err=%0d rdata=%h", o.err, o.rdata, e.err, e.rdata); end
        n_checks++; if (o.lat !== e.lat) begin n_fail++; $display("FAIL misalign_half.lat got=%0d exp=%0d", o.lat, e.lat); end
        issue(1'b1, 2'd2, 1'b0, 32'hBFC00102, 32'hCAFEF00D, 0, 32'h0, o);
        e = exp_q.pop_front();
        n_checks++; if (o.err !== e.err || o.bcyc !== e.bcyc) begin
            n_fail++; $display("FAIL misalign_word.resp got err=%0d bus=%0d exp err=%0d bus=%0d", o.err, o.bcyc, e.err, e.bcyc); end
        issue(1'b0, 2'd3, 1'b0, 32'hBFC00100, 32'h0, 0, 32'h0, o);
        e = exp_q.pop_front();
        n_checks++; if (o.err !== e.err || o.bcyc !== e.bcyc) begin
            n_fail++; $display("FAIL misalign_size3.resp got err=%0d bus=%0d exp err=%0d bus=%0d", o.err, o.bcyc, e.err, e.bcyc); end
    endtask

    task automatic test_wait_states();
        txn_t e, o;
        exp_q.push_back(mk(32'hBFC00200, 4'b1111, 32'h0, 1'b1, 1'b0, 4, 6, 32'h12345678, 2'd0));
        issue(1'b0, 2'd2, 1'b0, 32'hBFC00200, 32'h0, 3, 32'h12345678, o);
        e = exp_q.pop_front();
        n_checks++; if (o.bcyc !== e.bcyc) begin n_fail++; $display("FAIL wait3.bus_cycles got=%0d exp=%0d", o.bcyc, e.bcyc); end
        n_checks++; if (o.stable !== e.stable) begin n_fail++; $display("FAIL wait3.stable got=%b exp=%b", o.stable, e.stable); end
        n_checks++; if (o.lat !== e.lat) begin n_fail++; $display("FAIL wait3.lat got=%0d exp=%0d", o.lat, e.lat); end
        n_checks++; if (o.rdata !== e.rdata) begin n_fail++; $display("FAIL wait3.rdata got=%h exp=%h", o.rdata, e.rdata); end
    endtask

    task automatic test_timeout();
        txn_t e, o;
        exp_q.push_back(mk(32'hBFC00300, 4'b1111, 32'h0, 1'b1, 1'b0, 4, 5, 32'h0, 2'd2));
        exp_q.push_back(mk(32'hBFC00304, 4'b1111, 32'h55AA55AA, 1'b0, 1'b1, 1, 2, 32'h0, 2'd0));
        issue(1'b0, 2'd2, 1'b0, 32'hBFC00300, 32'h0, 1000, 32'h77777777, o);
        e = exp_q.pop_front();
        n_checks++; if (o.bcyc !== e.bcyc) begin n_fail++; $display("FAIL timeout.bus_cycles got=%0d exp=%0d", o.bcyc, e.bcyc); end
        n_checks++; if (o.lat !== e.lat) begin n_fail++; $display("FAIL timeout.lat got=%0d exp=%0d", o.lat, e.lat); end
        n_checks++; if (o.err !== e.err || o.rdata !== e.rdata) begin
            n_fail++; $display("FAIL timeout.resp got err=%0d rdata=%h exp err=%0d rdata=%h", o.err, o.rdata, e.err, e.rdata); end
        issue(1'b1, 2'd2, 1'b0, 32'hBFC00304, 32'h55AA55AA, 0, 32'h0, o);
        e = exp_q.pop_front();
        n_checks++; if (o.ready !== e.ready || o.lat !== e.lat || o.err !== e.err || o.wd !== e.wd) begin
            n_fail++; $display("FAIL timeout.next got ready=%b lat=%0d err=%0d wd=%h exp ready=%b lat=%0d err=%0d wd=%h",
                               o.ready, o.lat, o.err, o.wd, e.ready, e.lat, e.err, e.wd); end
    endtask

    task automatic test_reset_mid_bus();
        txn_t e, o;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
        req_addr = 32'hBFC00400; req_wdata = 32'h0; waitrequest = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (read !== 1'b1) begin n_fail++; $display("FAIL mid_reset.pre_read got=%b exp=1", read); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (read !== 1'b0 || write !== 1'b0) begin n_fail++; $display("FAIL mid_reset.strobes got=%b%b exp=00", read, write); end
        n_checks++; if (byteenable !== 4'h0 || address !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset.bus got be=%b addr=%h exp 0/0", byteenable, address); end
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset.handshake got resp_valid=%b req_ready=%b exp 0/1", resp_valid, req_ready); end
        @(negedge clk);
        reset = 1'b1;
        waitrequest = 1'b0;
        exp_q.push_back(mk(32'hBFC00404, 4'b0011, 32'h0000BEEF, 1'b0, 1'b1, 1, 2, 32'h0, 2'd0));
        issue(1'b1, 2'd1, 1'b0, 32'hBFC00404, 32'h1234BEEF, 0, 32'h0, o);
        e = exp_q.pop_front();
        n_checks++; if (o.lat !== e.lat || o.err !== e.err || o.be !== e.be || o.wd !== e.wd) begin
            n_fail++; $display("FAIL mid_reset.store got lat=%0d err=%0d be=%b wd=%h exp lat=%0d err=%0d be=%b wd=%h",
                               o.lat, o.err, o.be, o.wd, e.lat, e.err, e.be, e.wd); end
    endtask

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; waitrequest = 1'b0; readdata = 32'h0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b1;
        @(negedge clk);
        test_word_store();
        test_byte_load();
        test_half_access();
        test_misaligned();
        test_wait_states();
        test_timeout();
        test_reset_mid_bus();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
